axi_adapter_device: RTL and testbench
=====================================

AXI_ADAPTER_DEVICE -- requirements
Module: axi_adapter_device

Interface
REQ-001 Parameters: none. Widths come from top_pkg: AXI_AW=32 address, AXI_DW=32 data, AXI_DSW=4 strobe.
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-high.
REQ-004 axi_i  in  axi_pkg::axi_h2d_t  request from the crossbar.
  - Fields: aw_valid, aw_addr[AW], w_valid, w_data[DW], w_strb[DSW], b_ready, ar_valid, ar_addr[AW], r_ready.
REQ-005 axi_o  out  axi_pkg::axi_d2h_t  response to the crossbar.
  - Fields: aw_ready, w_ready, b_valid, b_resp[2], ar_ready, r_valid, r_data[DW], r_resp[2].
REQ-006 req_o  out  1  device request strobe.
REQ-007 gnt_i  in  1  device grant; the request is accepted in the cycle where req_o and gnt_i are both high.
REQ-008 we_o  out  1  1=write, 0=read.
REQ-009 be_o  out  DSW  byte enables.
REQ-010 addr_o  out  AW  byte address.
REQ-011 wdata_o  out  DW  write data.
REQ-012 valid_i  in  1  device response valid; the device returns one per granted request, writes included.
REQ-013 rdata_i  in  DW  read data, sampled when valid_i is high.
REQ-014 err_i  in  1  device error, sampled when valid_i is high.

Function
REQ-015 The FSM SHALL have four states:
  - IDLE: accept a transaction.
  - REQ: assert req_o until gnt_i.
  - WAIT: wait for valid_i.
  - RSP: present B or R until the matching ready.
REQ-016 Only one transaction SHALL be outstanding; aw_ready, w_ready and ar_ready SHALL be 0 outside IDLE.
REQ-017 Write accept (IDLE): only when aw_valid and w_valid are both 1, raise aw_ready and w_ready together in that cycle.
  - Capture aw_addr, w_data and w_strb, set we=1, go to REQ.
  - AW without W (or W without AW) is not accepted and waits.
REQ-018 Read accept (IDLE): when ar_valid=1 and no complete write is pending, raise ar_ready.
  - Capture ar_addr, set we=0, go to REQ.
  - Writes have fixed priority over reads.
REQ-019 In REQ, req_o=1, and addr_o, we_o, be_o and wdata_o SHALL hold the captured values.
  - Reads drive be_o=4'hF and wdata_o=0.
  - addr_o passes the full captured address unmodified.
REQ-020 REQ with gnt_i=1 SHALL go to WAIT, or directly to RSP if valid_i=1 in the same cycle.
  - req_o SHALL be high for exactly one cycle per transaction when gnt_i is tied to 1.
REQ-021 In WAIT, valid_i=1 SHALL capture rdata_i and err_i and go to RSP; valid_i in any other state SHALL be ignored.
REQ-022 In RSP, a write drives b_valid=1 and a read drives r_valid=1 with r_data set to the captured rdata.
  - resp = 2'b10 (SLVERR) if the captured err=1, else 2'b00 (OKAY).
  - Outputs hold stable until ready=1, then the FSM returns to IDLE.
REQ-023 Latency with gnt_i=1 and a device responding one cycle after grant, counting from the accept cycle C:
  - req_o high at C+1.
  - valid_i at C+2.
  - b_valid/r_valid at C+3.
  - Earliest next accept at C+4, if ready is high at C+3.
REQ-024 Outputs SHALL be registered or derived only from state; there SHALL be no combinational path from axi_i valids to req_o.
REQ-025 b_valid and r_valid SHALL never be high simultaneously.

Reset
REQ-026 While rst_i=1 the FSM SHALL be in IDLE.
  - Held at 0: req_o, we_o, be_o, addr_o, wdata_o, all axi_o valid and ready fields, r_data and both resp fields.
REQ-027 A reset mid-transaction SHALL drop the transaction without a response; a late valid_i after reset SHALL be ignored.

Structure
REQ-028 axi_pkg SHALL hold axi_h2d_t, axi_d2h_t and the resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - top_pkg holds AXI_AW, AXI_DW and AXI_DSW.
REQ-029 The block SHALL be a single module with no sub-modules; the state enum SHALL be local to the module.

Verification
REQ-030 Write 0xDEADBEEF, strb 4'hF, to 0x100010 with AW and W in the same cycle and gnt=1; device sets valid 1 cycle after grant.
  - Required: req_o/we_o=1 with addr 0x100010 one cycle after accept.
  - Required: b_valid with OKAY 2 cycles later.
REQ-031 Read from 0x30004 with the device returning 0x12345678 and err=1.
  - Required: r_valid, r_data=0x12345678, r_resp=SLVERR.
  - Required: be_o=4'hF during req.
REQ-032 AW valid 3 cycles before W.
  - Required: no aw_ready until W is valid.
  - Required: then aw_ready and w_ready both high in one cycle, captured addr correct.
REQ-033 Simultaneous write (AW+W) and read.
  - Required: the write is accepted first and ar_ready stays 0.
  - Required: the read is accepted after b_valid and b_ready handshake.
REQ-034 b_ready held low 5 cycles.
  - Required: b_valid and b_resp stable and no new accept.
  - Also: gnt_i delayed 2 cycles keeps req_o and addr_o stable.
REQ-035 Assert rst_i during WAIT, then pulse valid_i.
  - Required: IDLE and all valids 0.
  - Required: no response is produced.

Source files
------------

// File: rtl/axi_pkg.sv
// Simplified single-beat AXI channel bundles and response codes.
//   axi_h2d_t : host-to-device (crossbar request side)
//   axi_d2h_t : device-to-host (response side)
package axi_pkg;

    import top_pkg::*;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic               aw_valid;
        logic [AXI_AW-1:0]  aw_addr;
        logic               w_valid;
        logic [AXI_DW-1:0]  w_data;
        logic [AXI_DSW-1:0] w_strb;
        logic               b_ready;
        logic               ar_valid;
        logic [AXI_AW-1:0]  ar_addr;
        logic               r_ready;
    } axi_h2d_t;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic              b_valid;
        logic [1:0]        b_resp;
        logic              ar_ready;
        logic              r_valid;
        logic [AXI_DW-1:0] r_data;
        logic [1:0]        r_resp;
    } axi_d2h_t;

endpackage

// File: rtl/top_pkg.sv
// Top-level bus geometry shared by every block on the AXI crossbar.
//   AXI_AW  : address width in bits
//   AXI_DW  : data width in bits
//   AXI_DSW : strobe width (one bit per data byte)
package top_pkg;

    localparam int AXI_AW  = 32;
    localparam int AXI_DW  = 32;
    localparam int AXI_DSW = AXI_DW / 8;

endpackage

// File: rtl/axi_adapter_device.sv
// Bridges one AXI transaction at a time onto a simple req/gnt/valid
// device port.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   axi_i / axi_o : AXI request / response bundles (single beat)
//   req_o, gnt_i  : device request, accepted when both are high
//   we_o, be_o, addr_o, wdata_o : captured command, valid while req_o=1
//   valid_i, rdata_i, err_i     : device response (one per grant)
//   dbg_state_o   : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RSP)
//
// Handshake rule for every channel: a transfer happens in exactly the
// cycle where valid and ready are both high; a valid, once raised, holds
// its payload stable until that cycle, and ready may depend on valid.
module axi_adapter_device
    import top_pkg::*;
    import axi_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  axi_h2d_t           axi_i,
    output axi_d2h_t           axi_o,
    output logic               req_o,
    input  logic               gnt_i,
    output logic               we_o,
    output logic [AXI_DSW-1:0] be_o,
    output logic [AXI_AW-1:0]  addr_o,
    output logic [AXI_DW-1:0]  wdata_o,
    input  logic               valid_i,
    input  logic [AXI_DW-1:0]  rdata_i,
    input  logic               err_i,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e             state;
    logic               we_q;
    logic [AXI_AW-1:0]  addr_q;
    logic [AXI_DW-1:0]  wdata_q;
    logic [AXI_DSW-1:0] be_q;
    logic [AXI_DW-1:0]  rdata_q;
    logic               err_q;

    logic in_idle, in_req, in_rsp;
    logic write_acc, read_acc, rsp_ready;

    // Reset also gates the decodes so outputs are quiet from time zero,
    // before the first clock edge has had a chance to load the state.
    assign in_idle = (state == S_IDLE) && !rst_i;
    assign in_req  = (state == S_REQ)  && !rst_i;
    assign in_rsp  = (state == S_RSP)  && !rst_i;

    // A write needs both halves present; a lone AW or W just waits.
    // Writes win over a simultaneous read.
    assign write_acc = in_idle && axi_i.aw_valid && axi_i.w_valid;
    assign read_acc  = in_idle && axi_i.ar_valid && !(axi_i.aw_valid && axi_i.w_valid);
    assign rsp_ready = we_q ? axi_i.b_ready : axi_i.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (write_acc) begin
                        we_q    <= 1'b1;
                        addr_q  <= axi_i.aw_addr;
                        wdata_q <= axi_i.w_data;
                        be_q    <= axi_i.w_strb;
                        state   <= S_REQ;
                    end else if (read_acc) begin
                        we_q    <= 1'b0;
                        addr_q  <= axi_i.ar_addr;
                        wdata_q <= '0;
                        be_q    <= '1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (gnt_i) begin
                        // A device may answer in the grant cycle itself.
                        if (valid_i) begin
                            rdata_q <= rdata_i;
                            err_q   <= err_i;
                            state   <= S_RSP;
                        end else begin
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (valid_i) begin
                        rdata_q <= rdata_i;
                        err_q   <= err_i;
                        state   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_o       = in_req;
    assign we_o        = in_req ? we_q    : 1'b0;
    assign be_o        = in_req ? be_q    : '0;
    assign addr_o      = in_req ? addr_q  : '0;
    assign wdata_o     = in_req ? wdata_q : '0;
    assign dbg_state_o = state;

    always_comb begin
        axi_o          = '0;
        axi_o.aw_ready = write_acc;
        axi_o.w_ready  = write_acc;
        axi_o.ar_ready = read_acc;
        if (in_rsp && we_q) begin
            axi_o.b_valid = 1'b1;
            axi_o.b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
        if (in_rsp && !we_q) begin
            axi_o.r_valid = 1'b1;
            axi_o.r_data  = rdata_q;
            axi_o.r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi_adapter_device.sv
// Directed bench for axi_adapter_device: a table of transactions run
// through one transaction task, plus hand-written reset sequences.
module tb_axi_adapter_device;

    import top_pkg::*;
    import axi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_h2d_t           axi_i;
    axi_d2h_t           axi_o;
    logic               req_o, gnt, we_o, valid, err;
    logic [AXI_DSW-1:0] be_o;
    logic [AXI_AW-1:0]  addr_o;
    logic [AXI_DW-1:0]  wdata_o, rdata;
    logic [1:0]         dbg_state;

    axi_adapter_device dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_i      (axi_i),
        .axi_o      (axi_o),
        .req_o      (req_o),
        .gnt_i      (gnt),
        .we_o       (we_o),
        .be_o       (be_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .valid_i    (valid),
        .rdata_i    (rdata),
        .err_i      (err),
        .dbg_state_o(dbg_state)
    );

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        int          aw_lead;
        int          gnt_delay;
        int          bready_delay;
        logic        fast;
        logic        hold_ar;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic drive_idle();
        axi_i = '0;
        gnt   = 1'b0;
        valid = 1'b0;
        rdata = '0;
        err   = 1'b0;
    endtask

    // Called just after a falling edge; returns just after a falling edge
    // with the DUT back in IDLE, so calls chain back to back.
    task automatic do_txn(input vec_t v);
        for (int i = 0; i < v.aw_lead; i++) begin
            axi_i.aw_valid = 1'b1;
            axi_i.aw_addr  = v.addr;
            axi_i.w_valid  = 1'b0;
            #1;
            check("aw_alone_aw_ready", 32'(axi_o.aw_ready), 32'd0);
            check("aw_alone_w_ready", 32'(axi_o.w_ready), 32'd0);
            @(negedge clk);
        end

        // accept cycle
        axi_i.aw_addr  = v.addr;
        axi_i.ar_addr  = v.addr;
        axi_i.w_data   = v.data;
        axi_i.w_strb   = v.strb;
        axi_i.aw_valid = v.is_write;
        axi_i.w_valid  = v.is_write;
        axi_i.ar_valid = !v.is_write || v.hold_ar;
        #1;
        check("acc_aw_ready", 32'(axi_o.aw_ready), 32'(v.is_write));
        check("acc_w_ready", 32'(axi_o.w_ready), 32'(v.is_write));
        check("acc_ar_ready", 32'(axi_o.ar_ready), 32'(!v.is_write));
        check("acc_req_low", 32'(req_o), 32'd0);
        @(negedge clk);
        axi_i.aw_valid = 1'b0;
        axi_i.w_valid  = 1'b0;
        axi_i.ar_valid = v.hold_ar;
        axi_i.w_data   = 32'hFFFF_FFFF;

        // request phase
        for (int i = 0; i <= v.gnt_delay; i++) begin
            gnt   = (i == v.gnt_delay);
            valid = v.fast && gnt;
            rdata = v.rdata;
            err   = v.err;
            #1;
            check("req_o", 32'(req_o), 32'd1);
            check("req_state", 32'(dbg_state), 32'(ST_REQ));
            check("req_we", 32'(we_o), 32'(v.is_write));
            check("req_addr", addr_o, v.addr);
            check("req_be", 32'(be_o), 32'(v.exp_be));
            check("req_wdata", wdata_o, v.exp_wdata);
            check("req_ar_ready", 32'(axi_o.ar_ready), 32'd0);
            @(negedge clk);
        end
        gnt = 1'b0;

        if (!v.fast) begin
            valid = 1'b1;
            rdata = v.rdata;
            err   = v.err;
            #1;
            check("wait_state", 32'(dbg_state), 32'(ST_WAIT));
            check("wait_req_low", 32'(req_o), 32'd0);
            check("wait_b_valid", 32'(axi_o.b_valid), 32'd0);
            check("wait_r_valid", 32'(axi_o.r_valid), 32'd0);
            @(negedge clk);
        end
        // Garbage on the response bus now must not disturb captured values.
        valid = 1'b0;
        rdata = ~v.rdata;
        err   = ~v.err;

        // response phase, ready withheld for bready_delay cycles
        for (int i = 0; i <= v.bready_delay; i++) begin
            axi_i.b_ready  = v.is_write && (i == v.bready_delay);
            axi_i.r_ready  = !v.is_write && (i == v.bready_delay);
            axi_i.aw_valid = (i < v.bready_delay);
            axi_i.w_valid  = (i < v.bready_delay);
            #1;
            check("rsp_state", 32'(dbg_state), 32'(ST_RSP));
            check("rsp_b_valid", 32'(axi_o.b_valid), 32'(v.is_write));
            check("rsp_r_valid", 32'(axi_o.r_valid), 32'(!v.is_write));
            if (v.is_write) begin
                check("rsp_b_resp", 32'(axi_o.b_resp), 32'(v.exp_resp));
            end else begin
                check("rsp_r_resp", 32'(axi_o.r_resp), 32'(v.exp_resp));
                check("rsp_r_data", axi_o.r_data, v.exp_rdata);
            end
            check("rsp_aw_ready", 32'(axi_o.aw_ready), 32'd0);
            check("rsp_ar_ready", 32'(axi_o.ar_ready), 32'd0);
            check("rsp_req_low", 32'(req_o), 32'd0);
            @(negedge clk);
        end
        axi_i.b_ready  = 1'b0;
        axi_i.r_ready  = 1'b0;
        axi_i.aw_valid = 1'b0;
        axi_i.w_valid  = 1'b0;
        axi_i.ar_valid = v.hold_ar;
        rdata = '0;
        err   = 1'b0;
        #1;
        check("post_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("post_b_valid", 32'(axi_o.b_valid), 32'd0);
        check("post_r_valid", 32'(axi_o.r_valid), 32'd0);
        if (v.hold_ar) begin
            check("post_pending_read_ready", 32'(axi_o.ar_ready), 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        //           wr    addr           data           strb   rdata          err  lead gd br fast hold resp   be     wdata          rdata
        vecs[0] = '{1'b1, 32'h0010_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h0003_0004, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 1'b1, 0, 0, 0, 1'b0, 1'b0, 2'b10, 4'hF, 32'h0,        32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 4'h5, 32'h0,        1'b0, 3, 0, 0, 1'b0, 1'b0, 2'b00, 4'h5, 32'hA5A5_0F0F, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0044, 32'h1122_3344, 4'h3, 32'h0,        1'b1, 0, 2, 5, 1'b0, 1'b0, 2'b10, 4'h3, 32'h1122_3344, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0, 0, 0, 0, 1'b0, 1'b1, 2'b00, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_1111, 4'hF, 32'h0BAD_C0DE, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0,        32'h0BAD_C0DE};
        vecs[6] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, 32'h55AA_55AA, 1'b0, 0, 0, 2, 1'b1, 1'b0, 2'b00, 4'hF, 32'h0,        32'h55AA_55AA};
        vecs[7] = '{1'b1, 32'h7FFF_0000, 32'h0102_0304, 4'h8, 32'h0,        1'b1, 0, 0, 0, 1'b1, 1'b0, 2'b10, 4'h8, 32'h0102_0304, 32'h0};

        // reset, with a complete write offered that must not be accepted
        drive_idle();
        rst = 1'b1;
        axi_i.aw_valid = 1'b1;
        axi_i.w_valid  = 1'b1;
        axi_i.ar_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_aw_ready", 32'(axi_o.aw_ready), 32'd0);
        check("rst_ar_ready", 32'(axi_o.ar_ready), 32'd0);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_addr", addr_o, 32'h0);
        check("rst_d2h", 32'(axi_o.b_valid | axi_o.r_valid), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            do_txn(vecs[k]);
        end

        // reset while waiting for the device, then a late valid pulse
        @(negedge clk);
        axi_i.aw_valid = 1'b1;
        axi_i.w_valid  = 1'b1;
        axi_i.aw_addr  = 32'h0000_0C00;
        axi_i.w_data   = 32'h7777_7777;
        axi_i.w_strb   = 4'hF;
        @(negedge clk);
        axi_i.aw_valid = 1'b0;
        axi_i.w_valid  = 1'b0;
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #1;
        check("mid_rst_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_req", 32'(req_o), 32'd0);
        check("mid_rst_b_valid", 32'(axi_o.b_valid), 32'd0);
        rst   = 1'b0;
        valid = 1'b1;
        rdata = 32'h9999_9999;
        err   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("late_valid_state", 32'(dbg_state), 32'(ST_IDLE));
            check("late_valid_b_valid", 32'(axi_o.b_valid), 32'd0);
            check("late_valid_r_valid", 32'(axi_o.r_valid), 32'd0);
            @(negedge clk);
        end

        // the adapter still works after the aborted transaction
        do_txn(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
